pair_scheduler: RTL and testbench
=================================

PAIR_SCHEDULER -- requirements
Module: pair_scheduler

Interface
REQ-001 The block SHALL have parameter N, default 16, meaning the maximum number of bodies.
REQ-002 The block SHALL have parameter IDX_W, default $clog2(N), meaning the body index width.
REQ-003 The block SHALL have parameter MAX_INFLIGHT, default 8, meaning the maximum number of pairs outstanding in the force pipeline.
REQ-004 clk  input  1  clock; all state updates occur on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  starts one force sweep; sampled only in IDLE or DONE.
REQ-007 n_active  input  IDX_W+1  number of bodies in the sweep; latched when start is accepted.
REQ-008 pair_valid  output  1  a pair is offered to the force pipeline.
REQ-009 pair_ready  input  1  the force pipeline accepts the pair; transfer occurs when pair_valid and pair_ready are both high.
REQ-010 pair_i, pair_j  output  IDX_W each  indices of the base body and the source body.
REQ-011 pair_last  output  1  marks the final j for the current i.
REQ-012 res_valid  input  1  the pipeline returns one result, in issue order.
REQ-013 res_last  input  1  the returned result carries pair_last; valid only with res_valid.
REQ-014 body_done  output  1  one-cycle pulse indicating that the accumulation for body_idx is complete.
REQ-015 body_idx  output  IDX_W  index of the completed body.
REQ-016 busy  output  1  high in ISSUE and DRAIN.
REQ-017 done  output  1  high in DONE.
REQ-018 err  output  1  sticky flag for a protocol violation.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, ISSUE, DRAIN and DONE.
REQ-020 In IDLE or DONE, start with n_active>=2 SHALL latch n_active, set i=0, j=1, clear the body counter, and enter ISSUE; done drops in that same transition.
REQ-021 In IDLE or DONE, start with n_active<2 SHALL enter DONE, issue no pairs, and generate no body_done pulse.
REQ-022 n_active>N SHALL be treated as N.
REQ-023 In ISSUE, pair_valid SHALL be high exactly when inflight<MAX_INFLIGHT, and pair_i=i, pair_j=j.
REQ-024 Once pair_valid is asserted, pair_valid, pair_i, pair_j and pair_last SHALL remain stable until the transfer completes.
REQ-025 pair_j SHALL never equal pair_i.
REQ-026 The j sequence SHALL be 0..n-1 with i skipped.
REQ-027 pair_last SHALL be 1 when j is the last non-i index, i.e. j==n-1, or j==n-2 when i==n-1.
REQ-028 On a transfer with pair_last=0, j SHALL advance to the next non-i index.
REQ-029 On a transfer with pair_last=1 and i<n-1, i SHALL increment and j SHALL reset to 0.
REQ-030 On a transfer with pair_last=1 and i==n-1, the FSM SHALL enter DRAIN.
REQ-031 Total transfers per sweep SHALL equal n*(n-1).
REQ-032 The inflight counter SHALL be $clog2(MAX_INFLIGHT+1) bits: +1 on transfer, -1 on res_valid, unchanged when both occur in the same cycle.
REQ-033 res_valid while inflight==0 SHALL set err, leave inflight at 0, and be otherwise ignored.
REQ-034 In DRAIN, pair_valid SHALL be 0, and the FSM SHALL move to DONE on the cycle after inflight reaches 0.
REQ-035 res_valid&&res_last SHALL produce body_done=1 on the next cycle, with body_idx equal to the body counter value; the counter then increments.
REQ-036 When res_valid&&res_last occurs on consecutive cycles, body_done SHALL pulse on consecutive cycles.
REQ-037 DONE SHALL hold done=1 until a new start is accepted.
REQ-038 start SHALL be ignored in ISSUE and DRAIN.

Reset
REQ-039 reset SHALL force the IDLE state, clear inflight, i, j and the body counter, and drive pair_valid, pair_last, body_done, busy, done and err to 0.
REQ-040 reset SHALL take priority over all other inputs, including mid-sweep; results returning after reset SHALL count as REQ-033 violations.

Verification
REQ-041 n_active=4, pair_ready=1, pipeline latency 6 -> 12 transfers in order (0,1)(0,2)(0,3L)(1,0)(1,2)(1,3L)(2,0)(2,1)(2,3L)(3,0)(3,1)(3,2L); body_done for idx 0..3; done asserted 1 cycle after the 12th result.
REQ-042 MAX_INFLIGHT=2, results never returned -> exactly 2 transfers, then pair_valid=0 indefinitely with busy=1.
REQ-043 pair_ready toggles 1,0,0,1 while pair_valid=1 -> pair fields stable across stalls; no pair is lost or duplicated against a scoreboard.
REQ-044 n_active=1 start -> DONE on the next cycle with 0 transfers; n_active=N=16 -> 240 transfers and 16 body_done pulses.
REQ-045 reset after 5 transfers of a 4-body sweep -> IDLE on the next cycle, all outputs 0; a stray res_valid then sets err=1.
REQ-046 Same-cycle transfer and res_valid at inflight=MAX_INFLIGHT-1 -> inflight unchanged and pair_valid remains 1.

Source files
------------

// File: rtl/pair_if.sv
// Pair handshake bundle between the scheduler and the force pipeline.
// master: drives pair_valid/pair_i/pair_j/pair_last; receives pair_ready and results.
interface pair_if #(
    parameter int IDX_W = 4
);
    logic             pair_valid;
    logic             pair_ready;
    logic [IDX_W-1:0] pair_i;
    logic [IDX_W-1:0] pair_j;
    logic             pair_last;
    logic             res_valid;
    logic             res_last;

    modport master (
        output pair_valid, pair_i, pair_j, pair_last,
        input  pair_ready, res_valid, res_last
    );

    modport slave (
        input  pair_valid, pair_i, pair_j, pair_last,
        output pair_ready, res_valid, res_last
    );
endinterface

// File: rtl/pair_scheduler.sv
// All-pairs (i,j) issue scheduler for an N-body force pipeline.
// Ports: clk, reset (sync, active-high), start, n_active; pif (pair_if.master)
// carrying pairs out and in-order results back; body_done/body_idx pulse per
// finished body; busy (ISSUE/DRAIN), done (DONE), err (sticky stray result).
module pair_scheduler #(
    parameter int N            = 16,
    parameter int IDX_W        = $clog2(N),
    parameter int MAX_INFLIGHT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [IDX_W:0]   n_active,
    pair_if.master           pif,
    output logic             body_done,
    output logic [IDX_W-1:0] body_idx,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0]    MAX_C = CW'(MAX_INFLIGHT);
    localparam logic [IDX_W:0]   N_C   = (IDX_W + 1)'(N);
    localparam logic [IDX_W:0]   ONE   = (IDX_W + 1)'(1);
    localparam logic [IDX_W:0]   TWO   = (IDX_W + 1)'(2);
    localparam logic [IDX_W-1:0] J1    = IDX_W'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t           state;
    logic [IDX_W:0]   n;
    logic [IDX_W-1:0] i;
    logic [IDX_W-1:0] j;
    logic [IDX_W-1:0] body_cnt;
    logic [CW-1:0]    inflight;

    logic [IDX_W:0]   n_clamp;
    logic [IDX_W:0]   i_x;
    logic [IDX_W:0]   j_x;
    logic [IDX_W-1:0] j_inc;
    logic [IDX_W-1:0] j_nxt;
    logic             last_j;
    logic             xfer;
    logic             res_ok;

    always_comb begin
        n_clamp = (n_active > N_C) ? N_C : n_active;
        i_x     = {1'b0, i};
        j_x     = {1'b0, j};
        // final source index: n-1, unless that is the base body itself
        last_j  = (j_x == n - ONE) ||
                  ((i_x == n - ONE) && (j_x == n - TWO));
        j_inc   = j + 1'b1;
        j_nxt   = (j_inc == i) ? (j_inc + 1'b1) : j_inc;
        pif.pair_valid = (state == ISSUE) && (inflight < MAX_C);
        pif.pair_last  = (state == ISSUE) && last_j;
        pif.pair_i     = i;
        pif.pair_j     = j;
        xfer   = pif.pair_valid && pif.pair_ready;
        // a result with nothing outstanding is a protocol error, not a result
        res_ok = pif.res_valid && (inflight != '0);
        busy   = (state == ISSUE) || (state == DRAIN);
        done   = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            n         <= '0;
            i         <= '0;
            j         <= '0;
            body_cnt  <= '0;
            inflight  <= '0;
            body_done <= 1'b0;
            body_idx  <= '0;
            err       <= 1'b0;
        end else begin
            body_done <= 1'b0;
            if (pif.res_valid && inflight == '0)
                err <= 1'b1;
            if (res_ok && pif.res_last) begin
                body_done <= 1'b1;
                body_idx  <= body_cnt;
                body_cnt  <= body_cnt + 1'b1;
            end
            if (xfer && !res_ok)
                inflight <= inflight + 1'b1;
            else if (!xfer && res_ok)
                inflight <= inflight - 1'b1;

            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (n_clamp >= TWO) begin
                            n        <= n_clamp;
                            i        <= '0;
                            j        <= J1;
                            body_cnt <= '0;
                            state    <= ISSUE;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    if (xfer) begin
                        if (!last_j) begin
                            j <= j_nxt;
                        end else if (i_x != n - ONE) begin
                            i <= i + 1'b1;
                            j <= '0;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (inflight == '0)
                        state <= DONE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pair_scheduler.sv
// Scoreboard bench for pair_scheduler: directed sweeps, stalls, reset, throttle.
// Ports: none; drives two DUT instances (MAX_INFLIGHT 8 and 2).
module tb_pair_scheduler;
    localparam int N     = 16;
    localparam int IDX_W = 4;

    typedef struct {
        int i;
        int j;
        int last;
    } pair_t;

    typedef struct {
        int due;
        int last;
    } pend_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [IDX_W:0]   n_active = '0;
    logic             body_done;
    logic [IDX_W-1:0] body_idx;
    logic             busy;
    logic             done;
    logic             err;

    logic             start2 = 1'b0;
    logic [IDX_W:0]   n_active2 = '0;
    logic             body_done2;
    logic [IDX_W-1:0] body_idx2;
    logic             busy2;
    logic             done2;
    logic             err2;

    pair_if #(.IDX_W(IDX_W)) pif ();
    pair_if #(.IDX_W(IDX_W)) pif2 ();

    pair_scheduler #(
        .N(N), .IDX_W(IDX_W), .MAX_INFLIGHT(8)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .n_active(n_active), .pif(pif),
        .body_done(body_done), .body_idx(body_idx),
        .busy(busy), .done(done), .err(err)
    );

    pair_scheduler #(
        .N(N), .IDX_W(IDX_W), .MAX_INFLIGHT(2)
    ) u_dut2 (
        .clk(clk), .reset(reset), .start(start2),
        .n_active(n_active2), .pif(pif2),
        .body_done(body_done2), .body_idx(body_idx2),
        .busy(busy2), .done(done2), .err(err2)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    pair_t exp_q[$];
    int    exp_body[$];
    pend_t pq[$];

    int lat = 6;
    bit hold = 1'b0;
    bit flush = 1'b0;
    int stray_req = 0;
    int cyc = 0;
    int n_xfer = 0;
    int n_xfer2 = 0;
    int gaps = 0;
    int last_xfer_cyc = -10;
    int last_res_cyc = 0;
    int done_cyc = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference enumeration of a sweep, independent of the DUT's stepping
    task automatic push_sweep(input int n);
        int nn;
        int lj;
        nn = (n > N) ? N : n;
        if (nn >= 2) begin
            for (int a = 0; a < nn; a++) begin
                lj = (a == nn - 1) ? nn - 2 : nn - 1;
                for (int b = 0; b < nn; b++)
                    if (b != a)
                        exp_q.push_back('{a, b, int'(b == lj)});
                exp_body.push_back(a);
            end
        end
    endtask

    // monitor on negedge; result driver at posedge+1 (latency = lat cycles)
    initial begin
        pair_t e;
        pend_t p;
        int    stray_done;
        int    bi;
        bit    pv_q, pr_q, pl_q, rst_q, done_q;
        int    pi_q, pj_q;
        stray_done = 0;
        pv_q = 0; pr_q = 0; pl_q = 0; rst_q = 1; done_q = 0;
        pi_q = 0; pj_q = 0;
        pif.res_valid = 1'b0;
        pif.res_last = 1'b0;
        pif2.res_valid = 1'b0;
        pif2.res_last = 1'b0;
        forever begin
            @(negedge clk);
            if (pv_q && !pr_q && !rst_q) begin
                check("stall_valid", int'(pif.pair_valid), 1);
                check("stall_i", int'(pif.pair_i), pi_q);
                check("stall_j", int'(pif.pair_j), pj_q);
                check("stall_last", int'(pif.pair_last), int'(pl_q));
            end
            if (pif.pair_valid)
                check("j_ne_i", int'(pif.pair_j != pif.pair_i), 1);
            if (pif.pair_valid && pif.pair_ready && !reset) begin
                n_xfer++;
                if (cyc != last_xfer_cyc + 1)
                    gaps++;
                last_xfer_cyc = cyc;
                pq.push_back('{cyc + lat, int'(pif.pair_last)});
                check("pair_avail", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("pair_i", int'(pif.pair_i), e.i);
                    check("pair_j", int'(pif.pair_j), e.j);
                    check("pair_last", int'(pif.pair_last), e.last);
                end
            end
            if (body_done) begin
                check("body_avail", int'(exp_body.size() != 0), 1);
                if (exp_body.size() != 0) begin
                    bi = exp_body.pop_front();
                    check("body_idx", int'(body_idx), bi);
                end
            end
            if (done && !done_q)
                done_cyc = cyc;
            if (pif2.pair_valid && pif2.pair_ready)
                n_xfer2++;
            pv_q = pif.pair_valid;
            pr_q = pif.pair_ready;
            pl_q = pif.pair_last;
            pi_q = int'(pif.pair_i);
            pj_q = int'(pif.pair_j);
            rst_q = reset;
            done_q = done;

            @(posedge clk);
            #1;
            cyc++;
            if (flush)
                pq.delete();
            if (stray_req != stray_done) begin
                pif.res_valid = 1'b1;
                pif.res_last = 1'b0;
                stray_done++;
            end else if (!hold && pq.size() != 0 && pq[0].due <= cyc) begin
                p = pq.pop_front();
                pif.res_valid = 1'b1;
                pif.res_last = p.last[0];
                last_res_cyc = cyc;
            end else begin
                pif.res_valid = 1'b0;
                pif.res_last = 1'b0;
            end
        end
    end

    task automatic run_sweep(input int n, input int l, input int mode);
        int pat[4] = '{1, 0, 0, 1};
        int base;
        int nn;
        nn = (n > N) ? N : n;
        base = n_xfer;
        lat = l;
        n_active = (IDX_W + 1)'(n);
        pif.pair_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done_drop", int'(done), 0);
        check("busy_on", int'(busy), 1);
        for (int c = 0; c < 3000; c++) begin
            if (done)
                break;
            pif.pair_ready = (mode == 1) ? pat[c % 4][0] : 1'b1;
            // a start mid-sweep must not restart the sweep
            start = (mode == 1 && c == 10);
            tick();
        end
        start = 1'b0;
        pif.pair_ready = 1'b1;
        check("sweep_done", int'(done), 1);
        tick();
        tick();
        check("xfer_count", n_xfer - base, nn * (nn - 1));
        check("pairs_left", exp_q.size(), 0);
        check("bodies_left", exp_body.size(), 0);
        check("err_clear", int'(err), 0);
        // result accepted at edge m+1, DONE at edge m+2
        check("done_latency", done_cyc - last_res_cyc, 2);
        check("done_hold", int'(done), 1);
    endtask

    initial begin
        int tbl[12][3] = '{
            '{0, 1, 0}, '{0, 2, 0}, '{0, 3, 1},
            '{1, 0, 0}, '{1, 2, 0}, '{1, 3, 1},
            '{2, 0, 0}, '{2, 1, 0}, '{2, 3, 1},
            '{3, 0, 0}, '{3, 1, 0}, '{3, 2, 1}
        };
        int base;
        int g0;
        pif.pair_ready = 1'b1;
        pif2.pair_ready = 1'b1;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_valid", int'(pif.pair_valid), 0);
        check("rst_last", int'(pif.pair_last), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_body_done", int'(body_done), 0);

        // n=1: straight to DONE, nothing issued
        base = n_xfer;
        n_active = (IDX_W + 1)'(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("n1_done", int'(done), 1);
        check("n1_busy", int'(busy), 0);
        tick();
        check("n1_xfers", n_xfer - base, 0);

        // 4 bodies, latency 6, hand-written order
        for (int k = 0; k < 12; k++)
            exp_q.push_back('{tbl[k][0], tbl[k][1], tbl[k][2]});
        for (int b = 0; b < 4; b++)
            exp_body.push_back(b);
        run_sweep(4, 6, 0);

        // 4 bodies, ready stalls, restarted from DONE
        push_sweep(4);
        run_sweep(4, 3, 1);

        // 16 bodies, latency 7: inflight sits at 7 with both events per cycle
        g0 = gaps;
        push_sweep(16);
        run_sweep(16, 7, 0);
        check("no_throttle_gaps", gaps - g0, 1);

        // oversized n_active clamps to N
        push_sweep(31);
        run_sweep(31, 2, 0);

        // reset after 5 transfers, results held back
        hold = 1'b1;
        base = n_xfer;
        push_sweep(4);
        n_active = (IDX_W + 1)'(4);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (n_xfer - base >= 5)
                break;
            tick();
        end
        check("pre_rst_xfers", n_xfer - base, 5);
        reset = 1'b1;
        pif.pair_ready = 1'b0;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", int'(pif.pair_valid), 0);
        check("mid_rst_last", int'(pif.pair_last), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_err", int'(err), 0);
        check("mid_rst_body", int'(body_done), 0);
        exp_q.delete();
        exp_body.delete();
        flush = 1'b1;
        tick();
        tick();
        flush = 1'b0;
        hold = 1'b0;
        stray_req++;
        repeat (3) tick();
        check("stray_err", int'(err), 1);
        pif.pair_ready = 1'b1;

        // MAX_INFLIGHT=2, no results ever returned
        n_active2 = (IDX_W + 1)'(4);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (20) tick();
        check("thr_xfers", n_xfer2, 2);
        check("thr_valid", int'(pif2.pair_valid), 0);
        check("thr_busy", int'(busy2), 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
